// File: rtl/push_btn_filter_pkg.sv
// Shared definitions for the PushBtn input path: default debounce sizing and
// the push_btn_filter state encodings.
package push_btn_filter_pkg;

  localparam int PUSH_BTN_DEFAULT_WAIT = 40000;
  localparam int PUSH_BTN_DEFAULT_SIZE = 16;

  typedef enum logic [2:0] {
    PushBtnFilter_State_Idle        = 3'd0,
    PushBtnFilter_State_PressWait   = 3'd1,
    PushBtnFilter_State_Pressed     = 3'd2,
    PushBtnFilter_State_ReleaseWait = 3'd3,
    PushBtnFilter_State_Error       = 3'd4
  } push_btn_filter_state_t;

endpackage

// File: rtl/push_btn_filter_if.sv
// Pin-to-peripheral link of one push button: raw pad level in, debounced
// press pulse and held level out.
interface push_btn_filter_if;
  logic button;
  logic button_pressed;
  logic button_held;

  // The board/peripheral side drives the pad and consumes the filtered outputs.
  modport master (output button, input button_pressed, input button_held);
  modport slave  (input button, output button_pressed, output button_held);
endinterface

// File: rtl/sync_2ff.sv
// Parameter-free two-flop synchroniser for asynchronous pad inputs
// (buttons, switches), with a synchronous active-high reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync0;
  logic sync1;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge and form a true two-stage chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= d;
      sync1 <= sync0;
    end
  end

  assign q = sync1;

endmodule

// File: rtl/push_btn_filter.sv
// Synchronises and debounces one raw push button; emits a one-cycle pulse per
// accepted press and a level while the button is considered down.
module push_btn_filter
  import push_btn_filter_pkg::*;
#(
  parameter int Wait = PUSH_BTN_DEFAULT_WAIT,
  parameter int Size = PUSH_BTN_DEFAULT_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  push_btn_filter_if.slave  bus
);

  localparam logic [Size-1:0] CNT_LAST = Size'(Wait - 1);

  logic                   sync1;
  push_btn_filter_state_t state;
  logic [Size-1:0]        cnt;
  logic                   pressed_q;
  logic                   held_q;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.button),
    .q     (sync1)
  );

  // Outputs are registered and updated together with the state they describe,
  // so held_q always equals (state is Pressed or ReleaseWait).
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PushBtnFilter_State_Idle;
      cnt       <= '0;
      pressed_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      case (state)
        PushBtnFilter_State_Idle: begin
          held_q <= 1'b0;
          if (sync1) begin
            state <= PushBtnFilter_State_PressWait;
            cnt   <= '0;
          end
        end
        PushBtnFilter_State_PressWait: begin
          if (!sync1) begin
            state <= PushBtnFilter_State_Idle;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PushBtnFilter_State_Pressed;
            cnt       <= '0;
            pressed_q <= 1'b1;
            held_q    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PushBtnFilter_State_Pressed: begin
          held_q <= 1'b1;
          if (!sync1) begin
            state <= PushBtnFilter_State_ReleaseWait;
            cnt   <= '0;
          end
        end
        PushBtnFilter_State_ReleaseWait: begin
          if (sync1) begin
            state <= PushBtnFilter_State_Pressed;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= PushBtnFilter_State_Idle;
            cnt    <= '0;
            held_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PushBtnFilter_State_Error: begin
          held_q <= 1'b0;
        end
        default: begin
          // Corrupted encoding: park in the sticky Error state with outputs low.
          state  <= PushBtnFilter_State_Error;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.button_pressed = pressed_q;
  assign bus.button_held    = held_q;

endmodule
